// File: rtl/processor_fsm.sv
// Multicycle 10-instruction processor: FSM, unified instruction/data RAM, R0-R15, status flags.
// Optional debug ports (register peek, flags) are enabled with `define PROCESSOR_FSM_DEBUG_EN.
module processor_fsm #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     initialize_instructions,
    input  logic [ADDRESS_WIDTH-1:0] ram_init_wadrs,
    input  logic [DATA_WIDTH-1:0]    ram_write_instruction,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     halted
`ifdef PROCESSOR_FSM_DEBUG_EN
    ,
    input  logic [3:0]               dbg_reg_sel,
    output logic [DATA_WIDTH-1:0]    dbg_reg_data,
    output logic [4:0]               dbg_flags
`endif
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDRESS_WIDTH;
    localparam logic [DW-1:0] DW_C = DW'(DATA_WIDTH);

    localparam logic [3:0] OP_LD  = 4'd1;
    localparam logic [3:0] OP_STR = 4'd2;
    localparam logic [3:0] OP_BRA = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_ROT = 4'd6;
    localparam logic [3:0] OP_SHF = 4'd7;
    localparam logic [3:0] OP_HLT = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    state_t state, state_next;

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;

    logic [DW-1:0] regs [16];
    logic [31:0]   ir;
    logic [4:0]    flags;      // {carry, parity, even, negative, zero}
    logic [DW-1:0] result;
    logic          result_carry;

    // Fields of the latched instruction and of the word arriving from FETCH.
    logic [31:0] fetched;
    logic [3:0]  op, cond, fetched_op;
    logic        s_bit, d_bit;
    logic [11:0] src, dst, fetched_src, fetched_dst;

    always_comb begin
        fetched     = 32'(rdata);
        fetched_op  = fetched[31:28];
        fetched_src = fetched[23:12];
        fetched_dst = fetched[11:0];
        op    = ir[31:28];
        s_bit = ir[27];
        d_bit = ir[26];
        cond  = ir[27:24];
        src   = ir[23:12];
        dst   = ir[11:0];
    end

    // ALU operands and result, valid while in EXECUTE (rdata holds the operand read issued in DECODE).
    logic [DW-1:0] src_val, dst_reg, dst_val, amt, mag, rot_k, rot_left, rot_val, shf_val;
    logic [DW-1:0] alu_result;
    logic [DW:0]   sum;
    logic          amt_neg, alu_carry, taken;
    logic          is_dual, wb_reg, wb_mem, wb_flags;

    always_comb begin
        src_val  = s_bit ? regs[src[3:0]] : DW'(src);
        dst_reg  = regs[dst[3:0]];
        dst_val  = d_bit ? dst_reg : rdata;
        sum      = {1'b0, dst_val} + {1'b0, src_val};
        // Shift/rotate amounts are signed: an immediate amount is the 12-bit field sign-extended.
        amt      = s_bit ? regs[src[3:0]] : {{(DW-12){src[11]}}, src};
        amt_neg  = amt[DW-1];
        mag      = amt_neg ? (DW'(0) - amt) : amt;
        rot_k    = mag % DW_C;
        rot_left = amt_neg ? ((rot_k == '0) ? '0 : (DW_C - rot_k)) : rot_k;
        rot_val  = (dst_reg << rot_left) | (dst_reg >> (DW_C - rot_left));
        if (mag >= DW_C) begin
            shf_val = '0;
        end else begin
            shf_val = amt_neg ? (dst_reg >> mag) : (dst_reg << mag);
        end

        alu_result = '0;
        alu_carry  = 1'b0;
        case (op)
            OP_LD:   alu_result = rdata;
            OP_STR:  alu_result = src_val;
            OP_XOR:  alu_result = dst_val ^ src_val;
            OP_ADD:  {alu_carry, alu_result} = sum;
            OP_ROT:  alu_result = rot_val;
            OP_SHF:  alu_result = shf_val;
            OP_CMP:  alu_result = ~src_val;
            default: alu_result = '0;
        endcase

        case (cond)
            4'd0:    taken = 1'b1;
            4'd1:    taken = flags[3];
            4'd2:    taken = flags[2];
            4'd3:    taken = flags[4];
            4'd4:    taken = flags[1];
            4'd5:    taken = flags[0];
            4'd6:    taken = ~flags[4];
            4'd7:    taken = ~flags[1] & ~flags[0];
            default: taken = 1'b0;
        endcase

        is_dual  = (op == OP_XOR) || (op == OP_ADD) || (op == OP_CMP);
        wb_reg   = (op == OP_LD) || (op == OP_ROT) || (op == OP_SHF) || (is_dual && d_bit);
        wb_mem   = (op == OP_STR) || (is_dual && !d_bit);
        wb_flags = (op == OP_LD) || (op == OP_ROT) || (op == OP_SHF) || is_dual;
    end

    // Single RAM port: init write wins, otherwise the address follows the FSM phase.
    always_comb begin
        ram_addr  = pc;
        ram_we    = 1'b0;
        ram_wdata = result;
        if (initialize_instructions) begin
            ram_addr  = ram_init_wadrs;
            ram_we    = 1'b1;
            ram_wdata = ram_write_instruction;
        end else begin
            case (state)
                DECODE:    ram_addr = AW'((fetched_op == OP_LD) ? fetched_src : fetched_dst);
                WRITEBACK: begin
                    ram_addr = AW'(dst);
                    ram_we   = wb_mem;
                end
                default:   ram_addr = pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rdata <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:      state_next = FETCH;
            FETCH:     state_next = DECODE;
            DECODE:    state_next = EXECUTE;
            EXECUTE:   state_next = (op == OP_HLT) ? HALT : WRITEBACK;
            WRITEBACK: state_next = FETCH;
            HALT:      state_next = HALT;
            default:   state_next = INIT;
        endcase
        if (initialize_instructions) state_next = INIT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= '0;
            ir           <= '0;
            flags        <= '0;
            result       <= '0;
            result_carry <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (initialize_instructions) begin
            pc <= '0;
        end else begin
            case (state)
                DECODE: begin
                    ir <= fetched;
                    pc <= pc + AW'(1);
                end
                EXECUTE: begin
                    result       <= alu_result;
                    result_carry <= alu_carry;
                    if (op == OP_BRA && taken) pc <= AW'(dst);
                end
                WRITEBACK: begin
                    if (wb_reg) regs[dst[3:0]] <= result;
                    if (wb_flags) begin
                        flags <= {(op == OP_ADD) & result_carry, ^result, ~result[0],
                                  result[DW-1], (result == '0)};
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted = (state == HALT);

`ifdef PROCESSOR_FSM_DEBUG_EN
    assign dbg_reg_data = regs[dbg_reg_sel];
    assign dbg_flags    = flags;
`endif

endmodule

// File: tb/tb_processor_fsm.sv
// Bench for processor_fsm: loads small programs, runs to HALT and scores pc, registers and flags.
module tb_processor_fsm;

    logic        clk;
    logic        reset;
    logic        init;
    logic [11:0] wadrs;
    logic [31:0] wdata;
    logic [11:0] pc;
    logic        halted;
`ifdef PROCESSOR_FSM_DEBUG_EN
    logic [31:0] dbg_data;
    logic [4:0]  dbg_fl;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    processor_fsm #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .initialize_instructions (init),
        .ram_init_wadrs          (wadrs),
        .ram_write_instruction   (wdata),
        .pc                      (pc),
        .halted                  (halted)
`ifdef PROCESSOR_FSM_DEBUG_EN
        ,
        .dbg_reg_sel             (4'd0),
        .dbg_reg_data            (dbg_data),
        .dbg_flags               (dbg_fl)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard
    task automatic expect_v(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic score(input string tag, input logic [31:0] got);
        if (exp_q.size() == 0) check({tag, "_no_expect"}, 32'd0, 32'd1);
        else                   check(tag, got, exp_q.pop_front());
    endtask

    // drivers
    task automatic do_reset();
        @(negedge clk);
        init  = 1'b1;
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic load_word(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        init  = 1'b1;
        wadrs = a;
        wdata = d;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 48; i++) load_word(12'(i), 32'h0);
    endtask

    task automatic run_to_halt(input int budget);
        @(negedge clk);
        init = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        init  = 1'b1;
        wadrs = '0;
        wdata = '0;
        #1;
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_r1", dut.regs[1], 32'd0);
        check("reset_flags", 32'(dut.flags), 32'd0);
        #11;
        reset = 1'b1;

        // ADD R1,#5 ; HLT -- exact 8-clock latency from release
        clear_ram();
        load_word(12'd0, 32'h54005001);
        load_word(12'd1, 32'h80000000);
        expect_v(32'd0); expect_v(32'd1); expect_v(32'd2); expect_v(32'd5);
        @(negedge clk);
        init = 1'b0;
        repeat (7) @(posedge clk);
        #1 score("t2_halted_at7", 32'(halted));
        @(posedge clk);
        #1 score("t2_halted_at8", 32'(halted));
        score("t2_pc", 32'(pc));
        score("t2_r1", dut.regs[1]);

        // asynchronous reset mid-cycle, then INIT hold, then re-run from untouched RAM
        @(negedge clk);
        #2 reset = 1'b0;
        expect_v(32'd0); expect_v(32'd0); expect_v(32'd0);
        #1;
        score("t1_pc_async", 32'(pc));
        score("t1_halted_async", 32'(halted));
        score("t1_r1_async", dut.regs[1]);
        init = 1'b1;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        expect_v(32'd0); expect_v(32'd0);
        #1;
        score("t1_pc_init", 32'(pc));
        score("t1_halted_init", 32'(halted));
        expect_v(32'd2); expect_v(32'd5);
        run_to_halt(40);
        score("t1_rerun_pc", 32'(pc));
        score("t1_rerun_r1", dut.regs[1]);

        // STR #7 -> M32 ; LD R3,M32 ; HLT
        do_reset();
        clear_ram();
        load_word(12'd0, 32'h20007020);
        load_word(12'd1, 32'h14020003);
        load_word(12'd2, 32'h80000000);
        expect_v(32'd7); expect_v(32'h08); expect_v(32'd3);
        run_to_halt(60);
        score("t3_r3", dut.regs[3]);
        score("t3_flags", 32'(dut.flags));
        score("t3_pc", 32'(pc));

        // BRA always 9 skips a block of ADD R7,#1
        do_reset();
        clear_ram();
        load_word(12'd1, 32'h30000009);
        for (int a = 2; a <= 8; a++) load_word(12'(a), 32'h54001007);
        load_word(12'd9, 32'h80000000);
        expect_v(32'd10); expect_v(32'd0);
        run_to_halt(60);
        score("t4_pc", 32'(pc));
        score("t4_r7", dut.regs[7]);

        // ADD R1,#0 sets zero ; BRA zero 0x10 ; fall-through HLT at 2, target HLT at 0x10
        do_reset();
        clear_ram();
        load_word(12'd0, 32'h54000001);
        load_word(12'd1, 32'h35000010);
        load_word(12'd2, 32'h80000000);
        load_word(12'h10, 32'h80000000);
        expect_v(32'h11); expect_v(32'h05);
        run_to_halt(60);
        score("t5_pc", 32'(pc));
        score("t5_flags", 32'(dut.flags));

        // build R2=0x80000001, ROT +1, copy to R5, SHF by R4=-1
        do_reset();
        clear_ram();
        load_word(12'd0, 32'h54001002);
        load_word(12'd1, 32'h7401F002);
        load_word(12'd2, 32'h54001002);
        load_word(12'd3, 32'h94000004);
        load_word(12'd4, 32'h64001002);
        load_word(12'd5, 32'h4C002005);
        load_word(12'd6, 32'h7C004002);
        load_word(12'd7, 32'h80000000);
        expect_v(32'h3); expect_v(32'h1); expect_v(32'hFFFFFFFF); expect_v(32'h08); expect_v(32'd8);
        run_to_halt(100);
        score("t6_r5_rot", dut.regs[5]);
        score("t6_r2_shf", dut.regs[2]);
        score("t6_r4", dut.regs[4]);
        score("t6_flags", 32'(dut.flags));
        score("t6_pc", 32'(pc));

        // init from HALT without reset: pc cleared, registers kept
        @(negedge clk);
        init = 1'b1;
        repeat (2) @(posedge clk);
        expect_v(32'd0); expect_v(32'd0); expect_v(32'h1); expect_v(32'h3);
        #1;
        score("abort_pc", 32'(pc));
        score("abort_halted", 32'(halted));
        score("abort_r2", dut.regs[2]);
        score("abort_r5", dut.regs[5]);

        // carry branch, ROT amount >= width, SHF amount == width
        do_reset();
        clear_ram();
        load_word(12'd0, 32'h94000006);
        load_word(12'd1, 32'h54001006);
        load_word(12'd2, 32'h33000020);
        load_word(12'd3, 32'h80000000);
        load_word(12'h20, 32'h54FFF008);
        load_word(12'h21, 32'h54FFF009);
        load_word(12'h22, 32'h64024009);
        load_word(12'h23, 32'h74020008);
        load_word(12'h24, 32'h80000000);
        expect_v(32'h25); expect_v(32'h0); expect_v(32'hFFF0); expect_v(32'h0); expect_v(32'h05);
        run_to_halt(100);
        score("t7_pc", 32'(pc));
        score("t7_r6", dut.regs[6]);
        score("t7_r9_rot", dut.regs[9]);
        score("t7_r8_shf", dut.regs[8]);
        score("t7_flags", 32'(dut.flags));

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
